// File: rtl/sdram_port_master_if.sv
// Handshake and bus signals between the SDRAM port master, its FIFOs and the SDRAM controller.
interface sdram_port_master_if;
  logic        sdram_init_done;
  logic [9:0]  wr_fifo_level;
  logic [9:0]  rd_fifo_space;
  logic        rd_enable;
  logic        wr_fifo_rd_en;
  logic        rd_fifo_wr_en;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [20:0] sdram_wr_addr;
  logic [8:0]  sdram_wr_burst;
  logic        sdram_rd_req;
  logic        sdram_rd_ack;
  logic [20:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;

  modport master (
    input  sdram_init_done, wr_fifo_level, rd_fifo_space, rd_enable,
           sdram_wr_ack, sdram_rd_ack,
    output wr_fifo_rd_en, rd_fifo_wr_en, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_rd_req, sdram_rd_addr, sdram_rd_burst
  );

  modport slave (
    output sdram_init_done, wr_fifo_level, rd_fifo_space, rd_enable,
           sdram_wr_ack, sdram_rd_ack,
    input  wr_fifo_rd_en, rd_fifo_wr_en, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_rd_req, sdram_rd_addr, sdram_rd_burst
  );
endinterface

// File: rtl/sdram_port_master.sv
// Arbitrates write/read bursts between the FIFOs and the SDRAM controller.
// Optional SDRAM_PINGPANG_EN: address bit 20 selects a ping-pong bank.
module sdram_port_master #(
  parameter logic [8:0]  WR_BURST    = 9'd256,
  parameter logic [9:0]  RD_BURST    = 10'd256,
  parameter logic [20:0] WR_MIN_ADDR = 21'd0,
  parameter logic [20:0] WR_MAX_ADDR = 21'd786432,
  parameter logic [20:0] RD_MIN_ADDR = 21'd0,
  parameter logic [20:0] RD_MAX_ADDR = 21'd786432
) (
  input logic                 clk,
  input logic                 rst,
  sdram_port_master_if.master port
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

  state_t      state, state_nxt;
  logic        wr_req, rd_req, last_wr;
  logic        wr_ok, rd_ok, wr_done, rd_done, wr_wrap, rd_wrap;
  logic        bank_flip, rd_bank_load;
  logic [20:0] wr_addr, rd_addr;
  logic [19:0] wr_new, rd_new;

  assign wr_ok  = port.wr_fifo_level >= {1'b0, WR_BURST};
  assign rd_ok  = port.rd_enable && (port.rd_fifo_space >= RD_BURST);
  assign wr_new = wr_addr[19:0] + 20'(WR_BURST);
  assign rd_new = rd_addr[19:0] + 20'(RD_BURST);
  // MAX bounds the last word a burst may touch, so wrap once the next burst would run past it
  assign wr_wrap = (22'(wr_new) + 22'(WR_BURST)) > (22'(WR_MAX_ADDR) + 22'd1);
  assign rd_wrap = (22'(rd_new) + 22'(RD_BURST)) > (22'(RD_MAX_ADDR) + 22'd1);
  assign wr_done = (state == WR_XFER) && !port.sdram_wr_ack;
  assign rd_done = (state == RD_XFER) && !port.sdram_rd_ack;

`ifdef SDRAM_PINGPANG_EN
  logic started;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) started <= 1'b0;
    else     started <= 1'b1;
  end

  // both a write wrap and a read re-bank take the bank opposite the current write bank
  assign bank_flip    = ~wr_addr[20];
  assign rd_bank_load = ~started;
`else
  assign bank_flip    = 1'b0;
  assign rd_bank_load = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (port.sdram_init_done) begin
          if (wr_ok && (!rd_ok || !last_wr)) state_nxt = WR_REQ;
          else if (rd_ok)                    state_nxt = RD_REQ;
        end
      end
      WR_REQ:  if (port.sdram_wr_ack)  state_nxt = WR_XFER;
      WR_XFER: if (!port.sdram_wr_ack) state_nxt = IDLE;
      RD_REQ:  if (port.sdram_rd_ack)  state_nxt = RD_XFER;
      RD_XFER: if (!port.sdram_rd_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      last_wr <= 1'b0;
      wr_addr <= {1'b0, WR_MIN_ADDR[19:0]};
      rd_addr <= {1'b0, RD_MIN_ADDR[19:0]};
    end else begin
      state  <= state_nxt;
      wr_req <= (state_nxt == WR_REQ);
      rd_req <= (state_nxt == RD_REQ);
      if (wr_done) begin
        last_wr <= 1'b1;
        wr_addr <= wr_wrap ? {bank_flip, WR_MIN_ADDR[19:0]} : {wr_addr[20], wr_new};
      end
      if (rd_done) begin
        last_wr <= 1'b0;
        rd_addr <= rd_wrap ? {bank_flip, RD_MIN_ADDR[19:0]} : {rd_addr[20], rd_new};
      end else if (rd_bank_load) begin
        rd_addr[20] <= bank_flip;
      end
    end
  end

  assign port.sdram_wr_req   = wr_req;
  assign port.sdram_rd_req   = rd_req;
  assign port.sdram_wr_addr  = wr_addr;
  assign port.sdram_rd_addr  = rd_addr;
  assign port.sdram_wr_burst = WR_BURST;
  assign port.sdram_rd_burst = RD_BURST;
  assign port.wr_fifo_rd_en  = port.sdram_wr_ack && (state == WR_REQ || state == WR_XFER);
  assign port.rd_fifo_wr_en  = port.sdram_rd_ack && (state == RD_REQ || state == RD_XFER);

endmodule

// File: tb/tb_sdram_port_master.sv
// Randomized self-checking bench for sdram_port_master against a burst-index reference model.
module tb_sdram_port_master;

  localparam int WR_B   = 256;
  localparam int RD_B   = 256;
  localparam int WR_MIN = 0;
  localparam int WR_MAX = 1023;
  localparam int RD_MIN = 512;
  localparam int RD_MAX = 1535;
  localparam int WR_N   = (WR_MAX + 1 - WR_MIN) / WR_B;
  localparam int RD_N   = (RD_MAX + 1 - RD_MIN) / RD_B;
`ifdef SDRAM_PINGPANG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  sdram_port_master_if bus();

  sdram_port_master #(
    .WR_BURST   (9'd256),
    .RD_BURST   (10'd256),
    .WR_MIN_ADDR(21'd0),
    .WR_MAX_ADDR(21'd1023),
    .RD_MIN_ADDR(21'd512),
    .RD_MAX_ADDR(21'd1535)
  ) dut (
    .clk (clk),
    .rst (rst),
    .port(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: burst index inside each region plus bank bits and last grant
  int wr_idx, rd_idx;
  bit wr_bank, rd_bank, last_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [20:0] exp_wr_addr();
    logic [20:0] a;
    a     = 21'(WR_MIN + wr_idx * WR_B);
    a[20] = wr_bank;
    return a;
  endfunction

  function automatic logic [20:0] exp_rd_addr();
    logic [20:0] a;
    a     = 21'(RD_MIN + rd_idx * RD_B);
    a[20] = rd_bank;
    return a;
  endfunction

  function automatic bit wr_elig();
    return int'(bus.wr_fifo_level) >= WR_B;
  endfunction

  function automatic bit rd_elig();
    return bus.rd_enable && (int'(bus.rd_fifo_space) >= RD_B);
  endfunction

  task automatic model_reset();
    wr_idx  = 0;
    rd_idx  = 0;
    wr_bank = 1'b0;
    rd_bank = PP;
    last_wr = 1'b0;
  endtask

  task automatic set_inputs(input int wl, input bit re, input int sp);
    bus.wr_fifo_level = 10'(wl);
    bus.rd_enable     = re;
    bus.rd_fifo_space = 10'(sp);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check_eq("rst_wr_req", bus.sdram_wr_req, 0);
    check_eq("rst_rd_req", bus.sdram_rd_req, 0);
    check_eq("rst_wr_en", bus.wr_fifo_rd_en, 0);
    check_eq("rst_rd_en", bus.rd_fifo_wr_en, 0);
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    set_inputs(0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_eq("rst_wr_addr", bus.sdram_wr_addr, 21'(WR_MIN));
    check_eq("rst_rd_addr", bus.sdram_rd_addr, 21'(RD_MIN));
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // wait for a grant, check it against the model, then run ack for 'words' cycles
  task automatic serve_next(input int words, input int ack_delay,
                            output bit granted_wr, output logic [20:0] req_addr);
    bit exp_wr, is_wr;
    int lat, cnt;
    logic [20:0] held;
    granted_wr = 1'b0;
    req_addr   = '0;
    exp_wr     = wr_elig() && (!rd_elig() || !last_wr);
    lat        = 0;
    while (!(bus.sdram_wr_req || bus.sdram_rd_req) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("req_latency", lat, 1);
    if (!(bus.sdram_wr_req || bus.sdram_rd_req)) return;
    is_wr      = bus.sdram_wr_req;
    granted_wr = is_wr;
    check_eq("grant_is_write", is_wr, exp_wr);
    held     = is_wr ? bus.sdram_wr_addr : bus.sdram_rd_addr;
    req_addr = held;
    check_eq("req_addr", exp_wr ? bus.sdram_wr_addr : bus.sdram_rd_addr,
             exp_wr ? exp_wr_addr() : exp_rd_addr());
    repeat (ack_delay) @(negedge clk);
    check_eq("req_held", is_wr ? bus.sdram_wr_req : bus.sdram_rd_req, 1);
    check_eq("addr_held", is_wr ? bus.sdram_wr_addr : bus.sdram_rd_addr, held);
    cnt = 0;
    for (int i = 0; i < words; i++) begin
      bus.sdram_wr_ack = is_wr;
      bus.sdram_rd_ack = !is_wr;
      #1;
      if (is_wr ? bus.wr_fifo_rd_en : bus.rd_fifo_wr_en) cnt++;
      if (i == 1) check_eq("req_drop", is_wr ? bus.sdram_wr_req : bus.sdram_rd_req, 0);
      @(negedge clk);
    end
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    #1;
    check_eq("en_after_ack", is_wr ? bus.wr_fifo_rd_en : bus.rd_fifo_wr_en, 0);
    @(negedge clk);
    check_eq("enable_count", cnt, words);
    if (exp_wr) begin
      wr_idx++;
      if (wr_idx == WR_N) begin
        wr_idx = 0;
        if (PP) wr_bank = !wr_bank;
      end
      last_wr = 1'b1;
      check_eq("next_wr_addr", bus.sdram_wr_addr, exp_wr_addr());
    end else begin
      rd_idx++;
      if (rd_idx == RD_N) begin
        rd_idx = 0;
        if (PP) rd_bank = !wr_bank;
      end
      last_wr = 1'b0;
      check_eq("next_rd_addr", bus.sdram_rd_addr, exp_rd_addr());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit g0, g1, g2;
    logic [20:0] a;
    int c, lat, cnt;

    bus.sdram_init_done = 1'b0;
    bus.sdram_wr_ack    = 1'b0;
    bus.sdram_rd_ack    = 1'b0;
    set_inputs(0, 1'b0, 0);
    reset_dut();

    // no activity before init, then first write at address 0
    set_inputs(300, 1'b0, 0);
    c = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req) c++;
    end
    check_eq("no_req_before_init", c, 0);
    bus.sdram_init_done = 1'b1;
    serve_next(256, 0, g0, a);
    set_inputs(0, 1'b0, 0);
    check_eq("s1_is_write", g0, 1);
    check_eq("s1_first_addr", a, 0);
    check_eq("s2_next_wr_addr", bus.sdram_wr_addr, 256);

    // both eligible after reset: write, read, write
    reset_dut();
    set_inputs(256, 1'b1, 512);
    serve_next(20, 1, g0, a);
    check_eq("s3_addr0", a, 21'(WR_MIN));
    serve_next(20, 0, g1, a);
    check_eq("s3_addr1", a[19:0], 20'(RD_MIN));
    serve_next(20, 2, g2, a);
    check_eq("s3_addr2", a, 21'(WR_MIN + WR_B));
    set_inputs(0, 1'b0, 0);
    check_eq("s3_order0", g0, 1);
    check_eq("s3_order1", g1, 0);
    check_eq("s3_order2", g2, 1);

    // write wrap after four bursts
    reset_dut();
    set_inputs(256, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      serve_next(8, 0, g0, a);
      check_eq("s4_burst_addr", a[19:0], 20'(k * 256));
    end
    set_inputs(0, 1'b0, 0);
    check_eq("s4_wrap_low", bus.sdram_wr_addr[19:0], 0);
    check_eq("s4_wrap_bank", bus.sdram_wr_addr[20], PP);
    set_inputs(256, 1'b0, 0);
    serve_next(8, 0, g0, a);
    set_inputs(0, 1'b0, 0);
    check_eq("s4_fifth_addr", a[19:0], 0);

    // reset at word 100 of a write transfer
    set_inputs(256, 1'b0, 0);
    lat = 0;
    while (!bus.sdram_wr_req && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("s5_req_seen", bus.sdram_wr_req, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      bus.sdram_wr_ack = 1'b1;
      #1;
      if (bus.wr_fifo_rd_en) cnt++;
      @(negedge clk);
    end
    check_eq("s5_words", cnt, 100);
    reset_dut();
    set_inputs(256, 1'b0, 0);
    serve_next(16, 0, g0, a);
    set_inputs(0, 1'b0, 0);
    check_eq("s5_restart_addr", a, 21'(WR_MIN));

    // spurious read ack in IDLE
    c = 0;
    for (int i = 0; i < 5; i++) begin
      bus.sdram_rd_ack = 1'b1;
      #1;
      if (bus.rd_fifo_wr_en || bus.sdram_rd_req || bus.sdram_wr_req) c++;
      @(negedge clk);
    end
    bus.sdram_rd_ack = 1'b0;
    @(negedge clk);
    check_eq("s6_no_enable", c, 0);
    check_eq("s6_rd_addr", bus.sdram_rd_addr, exp_rd_addr());

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      set_inputs(int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1023)));
      if (wr_elig() || rd_elig()) begin
        serve_next(int'($urandom_range(2, 40)), int'($urandom_range(0, 3)), g0, a);
      end else begin
        c = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus.sdram_wr_req || bus.sdram_rd_req) c++;
        end
        check_eq("rand_idle_no_req", c, 0);
      end
    end
    set_inputs(0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
